maxnet_plu: RTL and testbench
=============================

Name: maxnet_plu

Overview:
- Processing unit for one Maxnet lateral-inhibition iteration; the responder to the controller's start_plu / plu_done handshake.
- On start it snapshots N activations and epsilon, then computes a_i' = max(0, a_i - eps * sum over j≠i of a_j) sequentially, one element per cycle.
- It then publishes the new vector with a one-cycle plu_done pulse.
- valid flags convergence: at most one nonzero activation remains.

Parameters:
N, 4, number of neurons (≥2)
W, 16, activation width, unsigned integer
EPS_W, 8, epsilon width, unsigned fraction Q0.EPS_W (eps = value/2^EPS_W)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin iteration; sampled only in IDLE
a_in  input  N*W  current activations, element i at bits [i*W +: W]
eps  input  EPS_W  inhibition coefficient
plu_done  output  1  one-cycle pulse, results valid
a_out  output  N*W  registered new activations, same packing as a_in
valid  output  1  nonzero count of a_out ≤ 1
winner  output  clog2(N)  lowest index with nonzero a_out (0 if none)
busy  output  1  high in SUM, UPDATE, DONE

Behaviour:
- Reset (async, rst_n=0): state IDLE; plu_done, busy, valid, winner, a_out, and all internal registers = 0.
- IDLE: on start=1 at a clock edge, capture a_in into snap[] and eps into eps_r; clear acc and idx; go to SUM.
- SUM (N cycles): acc += snap[idx]; idx++. After idx=N-1, reset idx to 0 and go to UPDATE. acc width W+clog2(N); no overflow possible.
- UPDATE (N cycles), per idx:
  - other = acc - snap[idx] (width W+clog2(N))
  - prod = (other * eps_r) >> EPS_W, floor (full product width before the shift)
  - res[idx] = (snap[idx] > prod) ? snap[idx] - prod : 0
  - idx++; after N-1, go to DONE.
- DONE (1 cycle), all on the same edge:
  - a_out <= res
  - valid <= (nonzero count of res ≤ 1)
  - winner <= lowest nonzero index
  - plu_done high for exactly this cycle; then IDLE.
- Latency: the edge sampling start is edge 0; plu_done is high in the cycle following edge 2N+1 (N=4: edge 9). busy is high from edge 1 through the plu_done cycle.
- a_out, valid, and winner hold between DONE events; they never change mid-computation.
- start while busy: ignored, no restart, no queuing. start held high continuously: a new iteration begins on the first IDLE edge after DONE.
- a_in and eps may change after the capture edge without affecting the result.
- Reset mid-operation: immediate return to IDLE; outputs cleared; no plu_done.
- eps=0: a_out = a_in.
- All-zero input: a_out = 0, valid=1, winner=0.
- Ties are not broken: equal activations stay equal and valid stays 0. The controller handles the iteration cap.

Test Plan:
1. Base iteration (N=4, W=16, EPS_W=8). Inputs: rst_n release, a_in={100,80,60,40} (idx0..3), eps=0x20, start pulse. Required: plu_done at edge 9, single cycle; a_out={78,55,33,10}; valid=0; busy high edges 1..9.
2. Single survivor. Inputs: a_in={100,0,0,0}, eps=0x20. Required: a_out={100,0,0,0}, valid=1, winner=0.
3. Clamp to zero. Inputs: a_in={10,200,0,0}, eps=0x80. Required: a_out={0,195,0,0}, valid=1, winner=1.
4. Tie. Inputs: a_in={50,50,0,0}, eps=0x80. Required: a_out={25,25,0,0}, valid=0, winner=0.
5. Protocol. Change a_in to all 0xFFFF and pulse start at edge 3 of a running case-1 iteration. Required: case-1 results unchanged, exactly one plu_done. Then assert rst_n=0 at edge 5 of a new run. Required: busy=0 and a_out=0 immediately; no plu_done afterwards.
6. Width stress. Inputs: a_in all 0xFFFF, eps=0xFF. Required: other=196605, prod=195837, every a_out=0, valid=1, winner=0, no wrap-around.

Source files
------------

// File: rtl/maxnet_plu.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_plu
// Description : One Maxnet lateral-inhibition iteration. Snapshots N
//               activations and epsilon on start, sums them, then computes
//               a_i' = max(0, a_i - eps * sum_{j!=i} a_j) one element per
//               cycle and publishes the result with a one-cycle plu_done.
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_plu #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int EPS_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N*W-1:0]         a_in,
    input  logic [EPS_W-1:0]       eps,
    output logic                   plu_done,
    output logic [N*W-1:0]         a_out,
    output logic                   valid,
    output logic [$clog2(N)-1:0]   winner,
    output logic                   busy
);

    localparam int IW = $clog2(N);
    localparam int AW = W + IW;        // sum of N activations cannot overflow
    localparam int PW = AW + EPS_W;    // full product width before the shift

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SUM    = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [W-1:0]         r_snap [N];
    logic [W-1:0]         r_res  [N];
    logic [EPS_W-1:0]     r_eps;
    logic [AW-1:0]        r_acc;
    logic [IW-1:0]        r_idx;
    logic [N*W-1:0]       r_a_out;
    logic                 r_valid;
    logic [IW-1:0]        r_winner;
    logic                 r_plu_done;

    logic                 w_last;
    logic [W-1:0]         w_cur;
    logic [AW-1:0]        w_other;
    logic [PW-1:0]        w_prod;
    logic [W-1:0]         w_res;
    logic                 w_seen;
    logic                 w_many;
    logic [IW-1:0]        w_first;

    assign w_last  = (r_idx == IW'(N - 1));
    assign w_cur   = r_snap[r_idx];
    assign w_other = r_acc - AW'(w_cur);
    // Floor of other*eps/2^EPS_W, computed at full width so nothing wraps
    assign w_prod  = (PW'(w_other) * PW'(r_eps)) >> EPS_W;
    assign w_res   = (PW'(w_cur) > w_prod) ? (w_cur - w_prod[W-1:0]) : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: SUM and UPDATE each walk idx across all N elements
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start)  w_next = S_SUM;
            S_SUM:    if (w_last) w_next = S_UPDATE;
            S_UPDATE: if (w_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Convergence summary of the result vector: more than one nonzero, lowest nonzero index
    always_comb begin
        w_seen  = 1'b0;
        w_many  = 1'b0;
        w_first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_res[i] != '0) begin
                w_first = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (r_res[i] != '0) begin
                if (w_seen) w_many = 1'b1;
                w_seen = 1'b1;
            end
        end
    end

    // Datapath: snapshot, accumulate, per-element update and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_snap[i] <= '0;
                r_res[i]  <= '0;
            end
            r_eps      <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_a_out    <= '0;
            r_valid    <= 1'b0;
            r_winner   <= '0;
            r_plu_done <= 1'b0;
        end else begin
            r_plu_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            r_snap[i] <= a_in[i*W +: W];
                        end
                        r_eps <= eps;
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                S_SUM: begin
                    r_acc <= r_acc + AW'(w_cur);
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                S_UPDATE: begin
                    r_res[r_idx] <= w_res;
                    r_idx        <= w_last ? '0 : r_idx + 1'b1;
                end
                S_DONE: begin
                    for (int i = 0; i < N; i++) begin
                        r_a_out[i*W +: W] <= r_res[i];
                    end
                    r_valid    <= ~w_many;
                    r_winner   <= w_first;
                    r_plu_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign plu_done = r_plu_done;
    assign a_out    = r_a_out;
    assign valid    = r_valid;
    assign winner   = r_winner;
    // Busy covers the whole computation including the cycle the result is announced
    assign busy     = (r_state != S_IDLE) || r_plu_done;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_plu.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxnet_plu
// Description : Directed self-checking bench for maxnet_plu (N=4, W=16,
//               EPS_W=8) using a vector table plus protocol sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxnet_plu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] a_in;
    logic [7:0]  eps;
    logic        plu_done;
    logic [63:0] a_out;
    logic        valid;
    logic [1:0]  winner;
    logic        busy;

    int total = 0;
    int bad   = 0;

    maxnet_plu #(.N(4), .W(16), .EPS_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .eps      (eps),
        .plu_done (plu_done),
        .a_out    (a_out),
        .valid    (valid),
        .winner   (winner),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [7:0]  e;
        logic [63:0] exp_a;
        logic        exp_v;
        logic [1:0]  exp_w;
    } vec_t;

    function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Launch one iteration and wait (bounded) for plu_done; reports latency and busy dropouts
    task automatic run(input logic [63:0] a, input logic [7:0] e, output int lat, output int busy_err);
        @(negedge clk);
        a_in  = a;
        eps   = e;
        start = 1'b1;
        @(posedge clk);          // edge 0
        #1;
        start    = 1'b0;
        busy_err = busy ? 0 : 1;
        lat      = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (!busy) busy_err++;
            if (plu_done) begin
                lat = k;
                break;
            end
        end
    endtask

    vec_t tbl[6];
    int   lat;
    int   berr;
    int   pulses;

    initial begin
        tbl[0] = '{"base",    pack4(100, 80, 60, 40),   8'h20, pack4(78, 55, 33, 10),  1'b0, 2'd0};
        tbl[1] = '{"single",  pack4(100, 0, 0, 0),      8'h20, pack4(100, 0, 0, 0),    1'b1, 2'd0};
        tbl[2] = '{"clamp",   pack4(10, 200, 0, 0),     8'h80, pack4(0, 195, 0, 0),    1'b1, 2'd1};
        tbl[3] = '{"tie",     pack4(50, 50, 0, 0),      8'h80, pack4(25, 25, 0, 0),    1'b0, 2'd0};
        tbl[4] = '{"eps0",    pack4(7, 3, 0, 9),        8'h00, pack4(7, 3, 0, 9),      1'b0, 2'd0};
        tbl[5] = '{"stress",  64'hFFFF_FFFF_FFFF_FFFF,  8'hFF, 64'd0,                  1'b1, 2'd0};

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        eps   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_out",    a_out,    64'd0);
        chk("reset_valid",    valid,    1'b0);
        chk("reset_winner",   winner,   2'd0);
        chk("reset_busy",     busy,     1'b0);
        chk("reset_plu_done", plu_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].a, tbl[i].e, lat, berr);
            chk({tbl[i].name, "_latency"}, lat, 9);
            chk({tbl[i].name, "_busy"},    berr, 0);
            chk({tbl[i].name, "_a_out"},   a_out, tbl[i].exp_a);
            chk({tbl[i].name, "_valid"},   valid, tbl[i].exp_v);
            chk({tbl[i].name, "_winner"},  winner, tbl[i].exp_w);
            @(posedge clk);
            #1;
            chk({tbl[i].name, "_pulse_width"}, plu_done, 1'b0);
            chk({tbl[i].name, "_busy_end"},    busy, 1'b0);
        end

        // Inputs changing and start re-pulsed mid-iteration must not disturb the result
        @(negedge clk);
        a_in  = pack4(100, 80, 60, 40);
        eps   = 8'h20;
        start = 1'b1;
        @(posedge clk);          // edge 0
        #1;
        start  = 1'b0;
        pulses = 0;
        lat    = -1;
        @(posedge clk);          // edge 1
        @(posedge clk);          // edge 2
        #1;
        a_in  = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1;
        @(posedge clk);          // edge 3
        #1;
        start = 1'b0;
        chk("proto_a_out_stable", a_out, 64'd0);
        for (int k = 4; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (plu_done) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        chk("proto_latency", lat, 9);
        chk("proto_pulses",  pulses, 1);
        chk("proto_a_out",   a_out, pack4(78, 55, 33, 10));
        chk("proto_valid",   valid, 1'b0);

        // Reset in the middle of a run clears everything and suppresses plu_done
        @(negedge clk);
        a_in  = pack4(10, 200, 0, 0);
        eps   = 8'h80;
        start = 1'b1;
        @(posedge clk);          // edge 0
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);   // edge 5
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",     busy,     1'b0);
        chk("rst_mid_a_out",    a_out,    64'd0);
        chk("rst_mid_plu_done", plu_done, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (plu_done) pulses++;
        end
        chk("rst_mid_no_done", pulses, 0);
        chk("rst_mid_idle",    busy,   1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
